// File: rtl/fetch_sequencer_pkg.sv
// ---------------------------------------------------------------------------
// fetch_sequencer_pkg
// Shared pipeline definitions for the instruction-fetch sequencer:
//   - state_t        : sequencer FSM encoding (RUN / HALT)
//   - PC_RESET_DEFAULT / PC_INC_DEFAULT : default fetch address and increment
//   - CNT_MAX        : saturation value of the 16-bit event counters
// ---------------------------------------------------------------------------
package fetch_sequencer_pkg;

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_HALT = 1'b1
    } state_t;

    localparam logic [15:0] PC_RESET_DEFAULT = 16'h0000;
    localparam logic [15:0] PC_INC_DEFAULT   = 16'd2;
    localparam logic [15:0] CNT_MAX          = 16'hFFFF;

endpackage

// File: rtl/fetch_sequencer_counter.sv
// ---------------------------------------------------------------------------
// sat_counter16
// 16-bit event counter with synchronous clear and saturation at 16'hFFFF.
// Ports:
//   clk    : clock
//   clear  : synchronous clear (wins over enable)
//   enable : count one event this cycle
//   count  : current count value
// ---------------------------------------------------------------------------
module sat_counter16
    import fetch_sequencer_pkg::*;
(
    input  logic        clk,
    input  logic        clear,
    input  logic        enable,
    output logic [15:0] count
);

    logic [15:0] count_reg;

    always_ff @(posedge clk) begin
        if (clear) begin
            count_reg <= 16'h0000;
        end else if (enable && (count_reg != CNT_MAX)) begin
            count_reg <= count_reg + 16'd1;
        end
    end

    assign count = count_reg;

endmodule

// File: rtl/fetch_sequencer.sv
// ---------------------------------------------------------------------------
// fetch_sequencer
// Chooses the next fetch address and the pipeline hold/flush controls from
// branch, jump, load-use and HALT events, and counts stall and redirect
// events.
// Parameters:
//   PC_RESET : fetch address presented while reset is high
//   PC_INC   : sequential fetch increment in bytes
// Ports:
//   clk, reset            : clock, synchronous active-high reset
//   pc_in                 : current program-counter value
//   load_use              : load-use hazard on the ID-stage instruction
//   branch_taken/_target  : EX-stage taken branch and its destination
//   jump/jump_target      : ID-stage jump and its destination
//   halt_detect           : ID-stage HALT decoded
//   resume                : restart request, used only while halted
//   next_pc               : address for the PC register
//   pc_stall              : PC holds its value
//   if_id_write           : 0 = IF/ID holds its value
//   if_id_flush           : IF/ID loads a NOP
//   id_ex_flush           : ID/EX loads a bubble
//   halted                : FSM is in HALT
//   stall_cnt / flush_cnt : saturating load-use stall / redirect counters
// ---------------------------------------------------------------------------
module fetch_sequencer
    import fetch_sequencer_pkg::*;
#(
    parameter logic [15:0] PC_RESET = PC_RESET_DEFAULT,
    parameter logic [15:0] PC_INC   = PC_INC_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] pc_in,
    input  logic        load_use,
    input  logic        branch_taken,
    input  logic [15:0] branch_target,
    input  logic        jump,
    input  logic [15:0] jump_target,
    input  logic        halt_detect,
    input  logic        resume,
    output logic [15:0] next_pc,
    output logic        pc_stall,
    output logic        if_id_write,
    output logic        if_id_flush,
    output logic        id_ex_flush,
    output logic        halted,
    output logic [15:0] stall_cnt,
    output logic [15:0] flush_cnt
);

    state_t      state_reg;
    logic [1:0]  cnt_en;          // [0] load-use stall, [1] redirect
    logic [15:0] cnt_val [2];

    // A halt_detect alongside a branch or jump belongs to the flushed path,
    // so HALT is entered only when it is the highest-priority event.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= ST_RUN;
        end else begin
            case (state_reg)
                ST_RUN: begin
                    if (!branch_taken && !jump && !load_use && halt_detect) begin
                        state_reg <= ST_HALT;
                    end
                end
                ST_HALT: begin
                    if (resume) begin
                        state_reg <= ST_RUN;
                    end
                end
                default: state_reg <= ST_RUN;
            endcase
        end
    end

    always_comb begin
        next_pc     = pc_in + PC_INC;
        pc_stall    = 1'b0;
        if_id_write = 1'b1;
        if_id_flush = 1'b0;
        id_ex_flush = 1'b0;
        halted      = 1'b0;
        cnt_en      = 2'b00;

        if (reset) begin
            next_pc     = PC_RESET;
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
        end else if (state_reg == ST_HALT) begin
            // Outputs stay at HALT values even in the resume cycle.
            halted      = 1'b1;
            pc_stall    = 1'b1;
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
            next_pc     = pc_in;
        end else if (branch_taken) begin
            next_pc     = branch_target;
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
            cnt_en[1]   = 1'b1;
        end else if (jump) begin
            next_pc     = jump_target;
            if_id_flush = 1'b1;
            cnt_en[1]   = 1'b1;
        end else if (load_use) begin
            next_pc     = pc_in;
            pc_stall    = 1'b1;
            if_id_write = 1'b0;
            id_ex_flush = 1'b1;
            cnt_en[0]   = 1'b1;
        end else if (halt_detect) begin
            next_pc     = pc_in;
            pc_stall    = 1'b1;
            if_id_flush = 1'b1;
        end
    end

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_cnt
            sat_counter16 u_cnt (
                .clk    (clk),
                .clear  (reset),
                .enable (cnt_en[gi]),
                .count  (cnt_val[gi])
            );
        end
    endgenerate

    assign stall_cnt = cnt_val[0];
    assign flush_cnt = cnt_val[1];

endmodule

// File: doc/fetch_sequencer.md
FETCH_SEQUENCER -- requirements
Module: fetch_sequencer

Interface
REQ-001 Parameter PC_RESET, default 16'h0000, fetch address driven on next_pc while reset is high.
REQ-002 Parameter PC_INC, default 16'd2, sequential fetch increment in bytes.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset, sampled on rising clk.
REQ-005 pc_in  input  16  current program-counter register value.
REQ-006 load_use  input  1  load-use hazard detected on the ID-stage instruction.
REQ-007 branch_taken  input  1  EX-stage branch resolved taken.
REQ-008 branch_target  input  16  EX-stage branch destination.
REQ-009 jump  input  1  ID-stage jump decoded.
REQ-010 jump_target  input  16  ID-stage jump destination.
REQ-011 halt_detect  input  1  ID-stage HALT instruction decoded.
REQ-012 resume  input  1  external restart request; meaningful only in HALT.
REQ-013 next_pc  output  16  address for the program-counter register.
REQ-014 pc_stall  output  1  1 = program counter holds its value.
REQ-015 if_id_write  output  1  0 = IF/ID register holds its value.
REQ-016 if_id_flush  output  1  1 = IF/ID register loads a NOP.
REQ-017 id_ex_flush  output  1  1 = ID/EX register loads a bubble.
REQ-018 halted  output  1  1 while the FSM is in HALT.
REQ-019 stall_cnt  output  16  count of load-use stall cycles.
REQ-020 flush_cnt  output  16  count of redirect events (branch or jump).

Function
REQ-021 The FSM SHALL have two states, RUN and HALT; all outputs except the counters are combinational from state and inputs.
REQ-022 In RUN, the block SHALL resolve events with fixed priority: branch_taken > jump > load_use > halt_detect > sequential.
REQ-023 For branch_taken in RUN: next_pc = branch_target, pc_stall=0, if_id_write=1, if_id_flush=1, id_ex_flush=1, flush_cnt +1.
REQ-024 For jump without branch_taken in RUN: next_pc = jump_target, pc_stall=0, if_id_flush=1, id_ex_flush=0, flush_cnt +1.
REQ-025 For load_use as the highest-priority event in RUN: pc_stall=1, if_id_write=0, id_ex_flush=1, next_pc = pc_in, stall_cnt +1, one count per asserted cycle.
REQ-026 For halt_detect as the highest-priority event in RUN: pc_stall=1, if_id_flush=1, next_pc = pc_in; the next state SHALL be HALT.
REQ-027 With no event in RUN: next_pc = pc_in + PC_INC, modulo 2^16 (16'hFFFE + 2 = 16'h0000), all stall and flush outputs 0, if_id_write=1.
REQ-028 In HALT: halted=1, pc_stall=1, if_id_flush=1, id_ex_flush=1, next_pc = pc_in; all other inputs except resume and reset SHALL be ignored.
REQ-029 In HALT with resume=1: the next state SHALL be RUN; outputs during that cycle remain the HALT values.
REQ-030 A halt_detect coincident with branch_taken or jump SHALL be discarded, because the instruction is on the flushed path.
REQ-031 stall_cnt and flush_cnt SHALL saturate at 16'hFFFF and never wrap.

Reset
REQ-032 While reset=1 the block SHALL drive: next_pc=PC_RESET, pc_stall=0, if_id_write=1, if_id_flush=1, id_ex_flush=1, halted=0.
REQ-033 On a rising edge with reset=1, the state SHALL become RUN and both counters SHALL become 0, overriding any simultaneous event, including reset asserted in HALT.

Structure
REQ-034 The state encoding (RUN, HALT), PC_RESET and PC_INC defaults SHALL reside in the shared pipeline package.
REQ-035 A single sub-module, sat_counter16 (enable, synchronous clear, saturating), SHALL be instantiated twice for stall_cnt and flush_cnt.

Verification
REQ-036 Reset, then pc_in=16'h0010 with no events -> next_pc=16'h0012, all flush and stall outputs 0.
REQ-037 pc_in=16'h0040 with branch_taken=1, branch_target=16'h0100, jump=1, load_use=1 -> next_pc=16'h0100, both flushes 1, flush_cnt +1, stall_cnt unchanged.
REQ-038 load_use=1 for 3 consecutive cycles at pc_in=16'h0020 -> next_pc=16'h0020, pc_stall=1, if_id_write=0 each cycle, stall_cnt=3.
REQ-039 halt_detect=1 -> halted=1 next cycle and held 5 cycles despite jump=1; resume=1 -> RUN, sequential fetch restarts from the held pc_in.
REQ-040 pc_in=16'hFFFE with no event -> next_pc=16'h0000; 65537 jumps -> flush_cnt=16'hFFFF; reset asserted in HALT -> RUN, counters 0, next_pc=PC_RESET.
